// File: rtl/div_arbiter.sv
// div_arbiter: shares one iterative 64-bit divider between two issue ports.
//
// Decodes RV64M DIV/DIVU/REM/REMU and their W variants, grants one port at a time
// (round-robin on contention), resolves divide-by-zero and signed overflow locally,
// sequences the divider start pulse / completion strobe and returns the selected,
// width-adjusted result over a valid/ready response channel.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   reqN_valid/ready          request handshake for port N (N = 0, 1)
//   reqN_op                   [1:0] 00 DIV, 01 DIVU, 10 REM, 11 REMU; [2] word variant
//   reqN_a, reqN_b            dividend, divisor
//   resp_valid/ready          response handshake
//   resp_id, resp_data        port the result belongs to, result
//   div_valid                 divider start (one-cycle pulse)
//   div_sign, div_x, div_y    divider signedness and operands (held outside LAUNCH)
//   div_data_ok               divider done strobe (one-cycle pulse)
//   div_q, div_r              divider quotient, remainder
//
// Optional feature: define DIV_ARB_RESULT_CACHE_EN to keep a one-entry cache of the
// last divider result; a request whose extended operands and signedness match the
// entry is answered without launching the divider.

module div_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [2:0]  req0_op,
   input  logic [63:0] req0_a,
   input  logic [63:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [2:0]  req1_op,
   input  logic [63:0] req1_a,
   input  logic [63:0] req1_b,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic        resp_id,
   output logic [63:0] resp_data,
   output logic        div_valid,
   output logic        div_sign,
   output logic [63:0] div_x,
   output logic [63:0] div_y,
   input  logic        div_data_ok,
   input  logic [63:0] div_q,
   input  logic [63:0] div_r
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] LAUNCH = 2'd1;
   localparam logic [1:0] WAIT   = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   localparam logic [63:0] MIN_S64 = 64'h8000_0000_0000_0000;

   // Word ops use only bits [31:0]; signedness picks sign- or zero-extension.
   function automatic logic [63:0] extend(input logic [63:0] v, input logic word,
                                          input logic sgn);
      logic [63:0] e;
      if (!word)    e = v;
      else if (sgn) e = {{32{v[31]}}, v[31:0]};
      else          e = {32'h0, v[31:0]};
      return e;
   endfunction

   function automatic logic [63:0] select_result(input logic [2:0] op, input logic [63:0] q,
                                                 input logic [63:0] r);
      logic [63:0] v;
      v = op[1] ? r : q;
      if (op[2]) v = {{32{v[31]}}, v[31:0]};
      return v;
   endfunction

   logic [1:0]  state_q, state_d;
   logic        rr_q;
   logic        id_q;
   logic [2:0]  op_q;
   logic [63:0] x_q, y_q;
   logic        sign_q;
   logic [63:0] data_q;

   logic        grant, accept;
   logic [2:0]  acc_op;
   logic [63:0] acc_a, acc_b, acc_ea, acc_eb;
   logic        acc_sgn;
   logic        div_zero, overflow, special;
   logic [63:0] spec_q, spec_r;
   logic        cache_hit;
   logic [63:0] hit_q, hit_r;

   // Arbitration: a lone valid port wins; on contention the round-robin pointer decides.
   always_comb begin
      grant      = (req0_valid && req1_valid) ? rr_q : req1_valid;
      accept     = (state_q == IDLE) && (req0_valid || req1_valid);
      req0_ready = accept && !grant;
      req1_ready = accept && grant;
   end

   // Operand decode for the granted port.
   always_comb begin
      acc_op   = grant ? req1_op : req0_op;
      acc_a    = grant ? req1_a  : req0_a;
      acc_b    = grant ? req1_b  : req0_b;
      acc_sgn  = ~acc_op[0];
      acc_ea   = extend(acc_a, acc_op[2], acc_sgn);
      acc_eb   = extend(acc_b, acc_op[2], acc_sgn);
      div_zero = (acc_eb == 64'h0);
      // Only the 64-bit signed form can overflow; W overflow fits in the 64-bit divide.
      overflow = acc_sgn && !acc_op[2] && (acc_ea == MIN_S64) && (acc_eb == '1);
      special  = div_zero || overflow;
      spec_q   = div_zero ? '1 : acc_ea;
      spec_r   = div_zero ? acc_ea : 64'h0;
   end

`ifdef DIV_ARB_RESULT_CACHE_EN
   logic        c_vld_q;
   logic [63:0] c_x_q, c_y_q, c_q_q, c_r_q;
   logic        c_sign_q;

   assign cache_hit = c_vld_q && (c_x_q == acc_ea) && (c_y_q == acc_eb) &&
                      (c_sign_q == acc_sgn);
   assign hit_q     = c_q_q;
   assign hit_r     = c_r_q;

   // Tag is the operand set actually handed to the divider for this result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_vld_q  <= 1'b0;
         c_x_q    <= 64'h0;
         c_y_q    <= 64'h0;
         c_sign_q <= 1'b0;
         c_q_q    <= 64'h0;
         c_r_q    <= 64'h0;
      end else if (state_q == WAIT && div_data_ok) begin
         c_vld_q  <= 1'b1;
         c_x_q    <= x_q;
         c_y_q    <= y_q;
         c_sign_q <= sign_q;
         c_q_q    <= div_q;
         c_r_q    <= div_r;
      end
   end
`else
   assign cache_hit = 1'b0;
   assign hit_q     = 64'h0;
   assign hit_r     = 64'h0;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = (special || cache_hit) ? RESP : LAUNCH;
         LAUNCH:  state_d = WAIT;
         WAIT:    if (div_data_ok) state_d = RESP;
         RESP:    if (resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rr_q    <= 1'b0;
         id_q    <= 1'b0;
         op_q    <= 3'h0;
         x_q     <= 64'h0;
         y_q     <= 64'h0;
         sign_q  <= 1'b0;
         data_q  <= 64'h0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            id_q <= grant;
            op_q <= acc_op;
            rr_q <= ~grant;
            if (special) begin
               data_q <= select_result(acc_op, spec_q, spec_r);
            end else if (cache_hit) begin
               data_q <= select_result(acc_op, hit_q, hit_r);
            end else begin
               // Divider operands change only when a launch follows.
               x_q    <= acc_ea;
               y_q    <= acc_eb;
               sign_q <= acc_sgn;
            end
         end
         if (state_q == WAIT && div_data_ok) begin
            data_q <= select_result(op_q, div_q, div_r);
         end
      end
   end

   assign div_valid  = (state_q == LAUNCH);
   assign div_sign   = sign_q;
   assign div_x      = x_q;
   assign div_y      = y_q;
   assign resp_valid = (state_q == RESP);
   assign resp_id    = id_q;
   assign resp_data  = data_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural variable-latency divider.
module tb_div_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [2:0]  req0_op, req1_op;
   logic [63:0] req0_a, req0_b, req1_a, req1_b;
   logic        resp_valid, resp_ready, resp_id;
   logic [63:0] resp_data;
   logic        div_valid, div_sign;
   logic [63:0] div_x, div_y;
   logic        div_data_ok;
   logic [63:0] div_q, div_r;

   int n_cmp = 0;
   int n_bad = 0;
   int div_lat = 0;
   int dv_cycles = 0;

   logic        r_id;
   logic [63:0] r_data;
   int          r_cyc, r_pulses;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   div_arbiter dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_data(resp_data),
      .div_valid(div_valid), .div_sign(div_sign), .div_x(div_x), .div_y(div_y),
      .div_data_ok(div_data_ok), .div_q(div_q), .div_r(div_r)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (div_valid === 1'b1) dv_cycles <= dv_cycles + 1;

   // Behavioural divider: latches operands on div_valid, answers div_lat cycles later.
   initial begin : divider_model
      logic [63:0] mx, my, mq, mr;
      logic        ms;
      bit          aborted;
      div_data_ok = 1'b0;
      div_q = 64'h0;
      div_r = 64'h0;
      forever begin
         @(posedge clk);
         if (div_valid === 1'b1 && rst !== 1'b1) begin
            mx = div_x; my = div_y; ms = div_sign;
            if (ms) begin
               mq = $signed(mx) / $signed(my);
               mr = $signed(mx) % $signed(my);
            end else begin
               mq = mx / my;
               mr = mx % my;
            end
            aborted = 1'b0;
            for (int k = 0; k < div_lat; k++) begin
               @(posedge clk);
               if (rst === 1'b1) begin
                  aborted = 1'b1;
                  break;
               end
            end
            if (!aborted) begin
               #1;
               div_data_ok = 1'b1; div_q = mq; div_r = mr;
               @(posedge clk);
               #1 div_data_ok = 1'b0;
            end
         end
      end
   end

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One complete transaction with resp_ready held high; reports id, data, the
   // negedge index (1 = cycle after accept) where resp_valid was seen, and div pulses.
   task automatic do_op(input bit port, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, output logic id, output logic [63:0] data,
                        output int cyc, output int pulses);
      int wait_n;
      int dv0;
      id = 1'b0; data = 64'h0; cyc = -1; pulses = -1;
      @(negedge clk);
      if (port) begin
         req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
      end else begin
         req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
      end
      #1;
      wait_n = 0;
      while (((port ? req1_ready : req0_ready) !== 1'b1) && wait_n < 50) begin
         @(negedge clk); #1; wait_n++;
      end
      if (wait_n >= 50) begin
         n_cmp++; n_bad++;
         $display("FAIL accept_timeout port=%0d got no ready, need ready within 50", port);
         req0_valid = 1'b0; req1_valid = 1'b0;
         return;
      end
      dv0 = dv_cycles;
      @(posedge clk);
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      cyc = 1;
      while (resp_valid !== 1'b1 && cyc < 100) begin
         @(negedge clk); cyc++;
      end
      if (cyc >= 100) begin
         n_cmp++; n_bad++;
         $display("FAIL resp_timeout op=%b got no resp_valid, need resp within 100", op);
         return;
      end
      id = resp_id;
      data = resp_data;
      @(posedge clk);
      #1;
      pulses = dv_cycles - dv0;
   endtask

   task automatic test_reset();
      n_cmp++;
      if ({req0_ready, req1_ready, resp_valid, resp_id, div_valid, div_sign} !== 6'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl got %b need 000000",
                  {req0_ready, req1_ready, resp_valid, resp_id, div_valid, div_sign});
      end
      n_cmp++;
      if (resp_data !== 64'h0) begin
         n_bad++; $display("FAIL reset_resp_data got %h need 0", resp_data);
      end
      n_cmp++;
      if ({div_x, div_y} !== 128'h0) begin
         n_bad++; $display("FAIL reset_div_xy got %h %h need 0 0", div_x, div_y);
      end
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      n_cmp++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         n_bad++; $display("FAIL reset_rr got %b need 10", {req0_ready, req1_ready});
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic test_divu();
      div_lat = 2;
      do_op(1'b0, 3'b001, 64'd100, 64'd7, r_id, r_data, r_cyc, r_pulses);
      n_cmp++;
      if (r_data !== 64'd14 || r_id !== 1'b0) begin
         n_bad++; $display("FAIL divu got id=%0d data=%h need id=0 data=e", r_id, r_data);
      end
      n_cmp++;
      if (r_pulses !== 1 || r_cyc !== 5) begin
         n_bad++;
         $display("FAIL divu_timing got pulses=%0d cyc=%0d need 1 5", r_pulses, r_cyc);
      end
      n_cmp++;
      if (resp_valid !== 1'b0) begin
         n_bad++; $display("FAIL resp_one_cycle got resp_valid=%b need 0", resp_valid);
      end
      n_cmp++;
      if (div_x !== 64'd100 || div_y !== 64'd7 || div_sign !== 1'b0) begin
         n_bad++;
         $display("FAIL divu_operands got %h %h %b need 64 7 0", div_x, div_y, div_sign);
      end
      do_op(1'b0, 3'b011, 64'd100, 64'd7, r_id, r_data, r_cyc, r_pulses);
      n_cmp++;
      if (r_data !== 64'd2 || r_pulses !== 1) begin
         n_bad++; $display("FAIL remu got %h pulses=%0d need 2 1", r_data, r_pulses);
      end
   endtask

   task automatic test_signed_word();
      div_lat = 0;
      do_op(1'b1, 3'b100, 64'hFFFF_FFFF_8000_0000, ONES, r_id, r_data, r_cyc, r_pulses);
      n_cmp++;
      if (r_data !== 64'hFFFF_FFFF_8000_0000 || r_id !== 1'b1 || r_cyc !== 3) begin
         n_bad++;
         $display("FAIL divw got data=%h id=%0d cyc=%0d need ffffffff80000000 1 3",
                  r_data, r_id, r_cyc);
      end
      n_cmp++;
      if (div_sign !== 1'b1 || div_x !== 64'hFFFF_FFFF_8000_0000 || div_y !== ONES) begin
         n_bad++;
         $display("FAIL divw_operands got %b %h %h need 1 ffffffff80000000 all-ones",
                  div_sign, div_x, div_y);
      end
      do_op(1'b1, 3'b111, 64'h1_0000_0007, 64'd2, r_id, r_data, r_cyc, r_pulses);
      n_cmp++;
      if (r_data !== 64'd1 || div_x !== 64'd7 || div_sign !== 1'b0) begin
         n_bad++;
         $display("FAIL remuw got data=%h x=%h sign=%b need 1 7 0", r_data, div_x, div_sign);
      end
      do_op(1'b1, 3'b101, 64'h0000_0000_F000_0000, 64'd1, r_id, r_data, r_cyc, r_pulses);
      n_cmp++;
      if (r_data !== 64'hFFFF_FFFF_F000_0000 || div_x !== 64'h0000_0000_F000_0000) begin
         n_bad++;
         $display("FAIL divuw got data=%h x=%h need fffffffff0000000 f0000000", r_data, div_x);
      end
      do_op(1'b0, 3'b000, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, r_id, r_data, r_cyc, r_pulses);
      n_cmp++;
      if (r_data !== 64'hFFFF_FFFF_FFFF_FFFD) begin
         n_bad++; $display("FAIL div_neg got %h need fffffffffffffffd", r_data);
      end
      do_op(1'b0, 3'b010, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, r_id, r_data, r_cyc, r_pulses);
      n_cmp++;
      if (r_data !== ONES) begin
         n_bad++; $display("FAIL rem_neg got %h need ffffffffffffffff", r_data);
      end
   endtask

   task automatic test_special();
      div_lat = 0;
      do_op(1'b0, 3'b000, 64'd5, 64'd0, r_id, r_data, r_cyc, r_pulses);
      n_cmp++;
      if (r_data !== ONES || r_cyc !== 1 || r_pulses !== 0) begin
         n_bad++;
         $display("FAIL div_by_zero got data=%h cyc=%0d pulses=%0d need all-ones 1 0",
                  r_data, r_cyc, r_pulses);
      end
      do_op(1'b0, 3'b010, 64'd5, 64'd0, r_id, r_data, r_cyc, r_pulses);
      n_cmp++;
      if (r_data !== 64'd5 || r_cyc !== 1 || r_pulses !== 0) begin
         n_bad++;
         $display("FAIL rem_by_zero got data=%h cyc=%0d pulses=%0d need 5 1 0",
                  r_data, r_cyc, r_pulses);
      end
      do_op(1'b1, 3'b000, 64'h8000_0000_0000_0000, ONES, r_id, r_data, r_cyc, r_pulses);
      n_cmp++;
      if (r_data !== 64'h8000_0000_0000_0000 || r_cyc !== 1 || r_pulses !== 0) begin
         n_bad++;
         $display("FAIL div_overflow got data=%h cyc=%0d pulses=%0d need 8000000000000000 1 0",
                  r_data, r_cyc, r_pulses);
      end
      do_op(1'b1, 3'b010, 64'h8000_0000_0000_0000, ONES, r_id, r_data, r_cyc, r_pulses);
      n_cmp++;
      if (r_data !== 64'h0 || r_pulses !== 0) begin
         n_bad++; $display("FAIL rem_overflow got %h pulses=%0d need 0 0", r_data, r_pulses);
      end
      do_op(1'b0, 3'b110, 64'h1_8000_0000, 64'hFFFF_FFFF_0000_0000, r_id, r_data, r_cyc,
            r_pulses);
      n_cmp++;
      if (r_data !== 64'hFFFF_FFFF_8000_0000 || r_pulses !== 0) begin
         n_bad++;
         $display("FAIL remw_by_zero got %h pulses=%0d need ffffffff80000000 0",
                  r_data, r_pulses);
      end
      n_cmp++;
      if (div_x !== 64'hFFFF_FFFF_FFFF_FFF9 || div_y !== 64'd2) begin
         n_bad++;
         $display("FAIL div_xy_hold got %h %h need fffffffffffffff9 2", div_x, div_y);
      end
      do_op(1'b0, 3'b001, 64'h8000_0000_0000_0000, ONES, r_id, r_data, r_cyc, r_pulses);
      n_cmp++;
      if (r_data !== 64'h0 || r_pulses !== 1) begin
         n_bad++; $display("FAIL divu_no_overflow got %h pulses=%0d need 0 1", r_data, r_pulses);
      end
   endtask

   task automatic test_round_robin();
      int  wait_n;
      logic g;
      apply_reset();
      div_lat = 1;
      @(negedge clk);
      req0_valid = 1'b1; req0_op = 3'b001; req0_a = 64'd40; req0_b = 64'd2;
      req1_valid = 1'b1; req1_op = 3'b001; req1_a = 64'd90; req1_b = 64'd3;
      for (int i = 0; i < 4; i++) begin
         #1;
         wait_n = 0;
         while ({req0_ready, req1_ready} === 2'b00 && wait_n < 50) begin
            @(negedge clk); #1; wait_n++;
         end
         n_cmp++;
         if ({req0_ready, req1_ready} !== (i[0] ? 2'b01 : 2'b10)) begin
            n_bad++;
            $display("FAIL rr_grant%0d got %b need %b", i, {req0_ready, req1_ready},
                     i[0] ? 2'b01 : 2'b10);
         end
         g = req1_ready;
         @(posedge clk);
         @(negedge clk);
         if (i == 3) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
         end
         wait_n = 0;
         while (resp_valid !== 1'b1 && wait_n < 50) begin
            @(negedge clk); wait_n++;
         end
         n_cmp++;
         if (resp_valid !== 1'b1 || resp_id !== g || resp_data !== (g ? 64'd30 : 64'd20)) begin
            n_bad++;
            $display("FAIL rr_resp%0d got v=%b id=%0d data=%h need 1 %0d %0d", i, resp_valid,
                     resp_id, resp_data, g, g ? 30 : 20);
         end
         @(posedge clk);
         @(negedge clk);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      int wait_n;
      div_lat = 0;
      @(negedge clk);
      resp_ready = 1'b0;
      req0_valid = 1'b1; req0_op = 3'b001; req0_a = 64'd100; req0_b = 64'd7;
      #1;
      wait_n = 0;
      while (req0_ready !== 1'b1 && wait_n < 50) begin
         @(negedge clk); #1; wait_n++;
      end
      @(posedge clk);
      @(negedge clk);
      // Both ports keep requesting while the response is stalled.
      req0_valid = 1'b1; req1_valid = 1'b1;
      req1_op = 3'b001; req1_a = 64'd90; req1_b = 64'd3;
      wait_n = 0;
      while (resp_valid !== 1'b1 && wait_n < 50) begin
         @(negedge clk); wait_n++;
      end
      for (int i = 0; i < 10; i++) begin
         #1;
         n_cmp++;
         if (resp_valid !== 1'b1 || resp_data !== 64'd14 || resp_id !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_resp%0d got v=%b data=%h id=%0d need 1 e 0", i, resp_valid,
                     resp_data, resp_id);
         end
         n_cmp++;
         if ({req0_ready, req1_ready} !== 2'b00) begin
            n_bad++; $display("FAIL stall_ready%0d got %b need 00", i, {req0_ready, req1_ready});
         end
         @(negedge clk);
      end
      resp_ready = 1'b1;
      req0_valid = 1'b0;
      #1;
      n_cmp++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
         n_bad++; $display("FAIL handshake_cycle_ready got %b need 00", {req0_ready, req1_ready});
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      n_cmp++;
      if (resp_valid !== 1'b0 || req1_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL after_handshake got resp_valid=%b req1_ready=%b need 0 1", resp_valid,
                  req1_ready);
      end
      @(posedge clk);
      @(negedge clk);
      req1_valid = 1'b0;
      wait_n = 0;
      while (resp_valid !== 1'b1 && wait_n < 50) begin
         @(negedge clk); wait_n++;
      end
      n_cmp++;
      if (resp_data !== 64'd30 || resp_id !== 1'b1) begin
         n_bad++; $display("FAIL held_req1 got data=%h id=%0d need 1e 1", resp_data, resp_id);
      end
      @(posedge clk);
   endtask

   task automatic test_reset_mid();
      int wait_n;
      div_lat = 20;
      @(negedge clk);
      req0_valid = 1'b1; req0_op = 3'b001; req0_a = 64'd100; req0_b = 64'd7;
      #1;
      wait_n = 0;
      while (req0_ready !== 1'b1 && wait_n < 50) begin
         @(negedge clk); #1; wait_n++;
      end
      @(posedge clk);
      @(negedge clk);
      req0_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({req0_ready, req1_ready, resp_valid, resp_id, div_valid, div_sign} !== 6'b0) begin
         n_bad++;
         $display("FAIL midreset_ctrl got %b need 000000",
                  {req0_ready, req1_ready, resp_valid, resp_id, div_valid, div_sign});
      end
      n_cmp++;
      if ({resp_data, div_x, div_y} !== 192'h0) begin
         n_bad++;
         $display("FAIL midreset_data got %h %h %h need 0 0 0", resp_data, div_x, div_y);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      div_lat = 0;
      do_op(1'b0, 3'b001, 64'd100, 64'd7, r_id, r_data, r_cyc, r_pulses);
      n_cmp++;
      if (r_data !== 64'd14 || r_pulses !== 1 || r_cyc !== 3) begin
         n_bad++;
         $display("FAIL post_reset_op got %h pulses=%0d cyc=%0d need e 1 3", r_data, r_pulses,
                  r_cyc);
      end
   endtask

   task automatic test_cache();
      apply_reset();
      div_lat = 3;
      do_op(1'b0, 3'b000, 64'd100, 64'd7, r_id, r_data, r_cyc, r_pulses);
      n_cmp++;
      if (r_data !== 64'd14 || r_pulses !== 1 || r_cyc !== 6) begin
         n_bad++;
         $display("FAIL cache_fill got %h pulses=%0d cyc=%0d need e 1 6", r_data, r_pulses,
                  r_cyc);
      end
      do_op(1'b1, 3'b010, 64'd100, 64'd7, r_id, r_data, r_cyc, r_pulses);
`ifdef DIV_ARB_RESULT_CACHE_EN
      n_cmp++;
      if (r_data !== 64'd2 || r_pulses !== 0 || r_cyc !== 1) begin
         n_bad++;
         $display("FAIL cache_hit got %h pulses=%0d cyc=%0d need 2 0 1", r_data, r_pulses,
                  r_cyc);
      end
`else
      n_cmp++;
      if (r_data !== 64'd2 || r_pulses !== 1 || r_cyc !== 6) begin
         n_bad++;
         $display("FAIL rem_repeat got %h pulses=%0d cyc=%0d need 2 1 6", r_data, r_pulses,
                  r_cyc);
      end
`endif
      do_op(1'b0, 3'b001, 64'd100, 64'd7, r_id, r_data, r_cyc, r_pulses);
      n_cmp++;
      if (r_data !== 64'd14 || r_pulses !== 1) begin
         n_bad++; $display("FAIL sign_miss got %h pulses=%0d need e 1", r_data, r_pulses);
      end
   endtask

   initial begin
      rst = 1'b1;
      req0_valid = 1'b0; req0_op = 3'h0; req0_a = 64'h0; req0_b = 64'h0;
      req1_valid = 1'b0; req1_op = 3'h0; req1_a = 64'h0; req1_b = 64'h0;
      resp_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_divu();
      test_signed_word();
      test_special();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
      test_cache();
      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
